// File: rtl/bayer_window_ctrl_if.sv
// Stream-side and window-side signals of the Bayer 3x3 window sequencer.
// master = pixel source / window consumer, slave = the sequencer itself.
interface bayer_window_ctrl_if #(
  parameter int unsigned CW = 11
);
  logic          iFVAL;
  logic          iDVAL;
  logic [11:0]   iDATA;

  logic [11:0]   oP_0;
  logic [11:0]   oP_1;
  logic [11:0]   oP_2;
  logic [11:0]   oP_3;
  logic [11:0]   oP_4;
  logic [11:0]   oP_5;
  logic [11:0]   oP_6;
  logic [11:0]   oP_7;
  logic [11:0]   oP_8;
  logic          oX_LSB;
  logic          oY_LSB;
  logic [CW-1:0] oX;
  logic [CW-1:0] oY;
  logic          oDVAL;
  logic          oFRAME_DONE;

  modport master (
    output iFVAL, iDVAL, iDATA,
    input  oP_0, oP_1, oP_2, oP_3, oP_4, oP_5, oP_6, oP_7, oP_8,
    input  oX_LSB, oY_LSB, oX, oY, oDVAL, oFRAME_DONE
  );

  modport slave (
    input  iFVAL, iDVAL, iDATA,
    output oP_0, oP_1, oP_2, oP_3, oP_4, oP_5, oP_6, oP_7, oP_8,
    output oX_LSB, oY_LSB, oX, oY, oDVAL, oFRAME_DONE
  );
endinterface

// File: rtl/bayer_window_ctrl.sv
// Raster-scan 3x3 window generator for a 12-bit Bayer stream: two line buffers,
// a shifting window register, pixel position tracking and frame-end flagging.
module bayer_window_ctrl #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned CW     = 11
) (
  input logic             iCLK,
  input logic             iRST_N,
  bayer_window_ctrl_if.slave bus
);

  localparam int unsigned AW    = $clog2(WIDTH);
  localparam logic [CW-1:0] XLast = CW'(WIDTH - 1);
  localparam logic [CW-1:0] YLast = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] YEnd  = CW'(HEIGHT);
  localparam logic [CW-1:0] Two   = CW'(2);
  localparam logic [CW-1:0] One   = CW'(1);

  logic [CW-1:0]     xQ, xD;
  logic [CW-1:0]     yQ, yD;
  logic              frameEnd;
  logic              accept;
  logic              winValid;
  logic              lastWin;
  logic [AW-1:0]     xIdx;

  logic [11:0]       lb1 [WIDTH];
  logic [11:0]       lb2 [WIDTH];
  logic [11:0]       lb1Rd;
  logic [11:0]       lb2Rd;

  // Index k matches oP_k: top row 0..2, middle 3..5, bottom 6..8; column 0 is newest.
  logic [8:0][11:0]  winQ, winD;

  logic              dvalQ;
  logic              doneQ;
  logic [CW-1:0]     oxQ;
  logic [CW-1:0]     oyQ;
  logic              xLsbQ;
  logic              yLsbQ;

  always_comb begin
    frameEnd = (yQ == YEnd);
    accept   = bus.iFVAL & bus.iDVAL & ~frameEnd;
    // Columns 0/1 still hold the previous line, so only x >= 2 yields a window.
    winValid = accept & (xQ >= Two) & (yQ >= Two);
    lastWin  = winValid & (xQ == XLast) & (yQ == YLast);
    xIdx     = xQ[AW-1:0];
    lb1Rd    = lb1[xIdx];
    lb2Rd    = lb2[xIdx];
  end

  always_comb begin
    xD = xQ;
    yD = yQ;
    if (!bus.iFVAL) begin
      xD = '0;
      yD = '0;
    end else if (accept) begin
      if (xQ == XLast) begin
        xD = '0;
        yD = yQ + One;
      end else begin
        xD = xQ + One;
      end
    end
  end

  always_comb begin
    winD = winQ;
    if (accept) begin
      winD[0] = lb2Rd;
      winD[1] = winQ[0];
      winD[2] = winQ[1];
      winD[3] = lb1Rd;
      winD[4] = winQ[3];
      winD[5] = winQ[4];
      winD[6] = bus.iDATA;
      winD[7] = winQ[6];
      winD[8] = winQ[7];
    end
  end

  // Line buffers are plain RAM with no reset; nonblocking writes give read-before-write.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      lb2[xIdx] <= lb1Rd;
      lb1[xIdx] <= bus.iDATA;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      xQ    <= '0;
      yQ    <= '0;
      winQ  <= '0;
      dvalQ <= 1'b0;
      doneQ <= 1'b0;
      oxQ   <= '0;
      oyQ   <= '0;
      xLsbQ <= 1'b0;
      yLsbQ <= 1'b0;
    end else begin
      xQ    <= xD;
      yQ    <= yD;
      winQ  <= winD;
      dvalQ <= winValid;
      doneQ <= lastWin;
      if (winValid) begin
        oxQ   <= xQ - One;
        oyQ   <= yQ - One;
        xLsbQ <= ~xQ[0];
        yLsbQ <= ~yQ[0];
      end
    end
  end

  assign bus.oP_0        = winQ[0];
  assign bus.oP_1        = winQ[1];
  assign bus.oP_2        = winQ[2];
  assign bus.oP_3        = winQ[3];
  assign bus.oP_4        = winQ[4];
  assign bus.oP_5        = winQ[5];
  assign bus.oP_6        = winQ[6];
  assign bus.oP_7        = winQ[7];
  assign bus.oP_8        = winQ[8];
  assign bus.oX          = oxQ;
  assign bus.oY          = oyQ;
  assign bus.oX_LSB      = xLsbQ;
  assign bus.oY_LSB      = yLsbQ;
  assign bus.oDVAL       = dvalQ;
  assign bus.oFRAME_DONE = doneQ;

endmodule

// File: tb/tb_bayer_window_ctrl.sv
// Directed bench for bayer_window_ctrl on a 4x4 frame: table-driven frames plus
// hand sequences for frame abandon and asynchronous mid-line reset.
module tb_bayer_window_ctrl;

  localparam int unsigned W   = 4;
  localparam int unsigned H   = 4;
  localparam int unsigned CWB = 3;

  typedef struct packed {
    logic             fval;
    logic             dval;
    logic [11:0]      data;
    logic             expDval;
    logic             expDone;
    logic [8:0][11:0] expP;
    logic [CWB-1:0]   expX;
    logic [CWB-1:0]   expY;
  } vec_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  bayer_window_ctrl_if #(.CW(CWB)) bus ();

  bayer_window_ctrl #(
    .WIDTH  (W),
    .HEIGHT (H),
    .CW     (CWB)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rstN),
    .bus    (bus)
  );

  int   nCmp = 0;
  int   nErr = 0;
  int   pulses;
  int   dones;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chkWin(input string tag, input logic [8:0][11:0] e);
    chk({tag, ".P0"}, 32'(bus.oP_0), 32'(e[0]));
    chk({tag, ".P1"}, 32'(bus.oP_1), 32'(e[1]));
    chk({tag, ".P2"}, 32'(bus.oP_2), 32'(e[2]));
    chk({tag, ".P3"}, 32'(bus.oP_3), 32'(e[3]));
    chk({tag, ".P4"}, 32'(bus.oP_4), 32'(e[4]));
    chk({tag, ".P5"}, 32'(bus.oP_5), 32'(e[5]));
    chk({tag, ".P6"}, 32'(bus.oP_6), 32'(e[6]));
    chk({tag, ".P7"}, 32'(bus.oP_7), 32'(e[7]));
    chk({tag, ".P8"}, 32'(bus.oP_8), 32'(e[8]));
  endtask

  task automatic tick(input logic f, input logic d, input logic [11:0] data);
    bus.iFVAL = f;
    bus.iDVAL = d;
    bus.iDATA = data;
    @(posedge clk);
    #1;
  endtask

  task automatic addIdle();
    vec_t v;
    v = '0;
    vecs.push_back(v);
  endtask

  // Accept at (x,y) with window P_k = pixel (x - k%3, y - 2 + k/3).
  task automatic addFrame(input int base, input int nLines);
    vec_t v;
    for (int y = 0; y < nLines; y++) begin
      for (int x = 0; x < int'(W); x++) begin
        v      = '0;
        v.fval = 1'b1;
        v.dval = 1'b1;
        v.data = 12'(base + 16 * y + x);
        if (x >= 2 && y >= 2) begin
          v.expDval = 1'b1;
          v.expDone = (x == int'(W) - 1) && (y == int'(H) - 1);
          v.expX    = CWB'(x - 1);
          v.expY    = CWB'(y - 1);
          for (int k = 0; k < 9; k++)
            v.expP[k] = 12'(base + 16 * (y - 2 + k / 3) + (x - k % 3));
        end
        vecs.push_back(v);
      end
    end
  endtask

  task automatic addExtra(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v      = '0;
      v.fval = 1'b1;
      v.dval = 1'b1;
      v.data = 12'(999 + i);
      vecs.push_back(v);
    end
  endtask

  // duty = percent chance iDVAL is high on a given cycle of an active stream.
  task automatic applyVecs(input string tag, input int duty);
    pulses = 0;
    dones  = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].fval && vecs[i].dval) begin
        for (int g = 0; g < 20 && $urandom_range(99) >= duty; g++) begin
          tick(1'b1, 1'b0, 12'hABC);
          chk({tag, ".gap_dval"}, 32'(bus.oDVAL), 0);
          chk({tag, ".gap_done"}, 32'(bus.oFRAME_DONE), 0);
        end
      end
      tick(vecs[i].fval, vecs[i].dval, vecs[i].data);
      chk({tag, ".dval"}, 32'(bus.oDVAL), 32'(vecs[i].expDval));
      chk({tag, ".done"}, 32'(bus.oFRAME_DONE), 32'(vecs[i].expDone));
      if (bus.oDVAL) pulses++;
      if (bus.oFRAME_DONE) dones++;
      if (vecs[i].expDval) begin
        chkWin(tag, vecs[i].expP);
        chk({tag, ".oX"}, 32'(bus.oX), 32'(vecs[i].expX));
        chk({tag, ".oY"}, 32'(bus.oY), 32'(vecs[i].expY));
        chk({tag, ".xlsb"}, 32'(bus.oX_LSB), 32'(vecs[i].expX[0]));
        chk({tag, ".ylsb"}, 32'(bus.oY_LSB), 32'(vecs[i].expY[0]));
      end
    end
  endtask

  task automatic chkAllZero(input string tag);
    chkWin(tag, '0);
    chk({tag, ".dval"}, 32'(bus.oDVAL), 0);
    chk({tag, ".done"}, 32'(bus.oFRAME_DONE), 0);
    chk({tag, ".oX"}, 32'(bus.oX), 0);
    chk({tag, ".oY"}, 32'(bus.oY), 0);
    chk({tag, ".xlsb"}, 32'(bus.oX_LSB), 0);
    chk({tag, ".ylsb"}, 32'(bus.oY_LSB), 0);
  endtask

  initial begin
    logic [8:0][11:0] first;
    int               manPulses;

    bus.iFVAL = 1'b0;
    bus.iDVAL = 1'b0;
    bus.iDATA = '0;
    rstN      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkAllZero("reset");
    @(negedge clk);
    rstN = 1'b1;

    // Continuous frame, ignored tail pixels, then a second frame with offset data.
    vecs.delete();
    addIdle();
    addFrame(0, H);
    addExtra(5);
    addIdle();
    addFrame(100, H);
    applyVecs("cont", 100);
    chk("cont.pulses", 32'(pulses), 8);
    chk("cont.dones", 32'(dones), 2);

    // Same frame with a 30% iDVAL duty.
    vecs.delete();
    addIdle();
    addFrame(0, H);
    applyVecs("duty30", 30);
    chk("duty30.pulses", 32'(pulses), 4);
    chk("duty30.dones", 32'(dones), 1);

    // Frame abandoned after line 2, then a full frame from fresh data.
    vecs.delete();
    addIdle();
    addFrame(200, 3);
    addIdle();
    addFrame(300, H);
    applyVecs("abandon", 100);
    chk("abandon.pulses", 32'(pulses), 6);
    chk("abandon.dones", 32'(dones), 1);

    // Part of a line, then asynchronous reset between edges.
    tick(1'b0, 1'b0, '0);
    for (int p = 0; p <= 10; p++) tick(1'b1, 1'b1, 12'(16 * (p / 4) + p % 4));
    chk("prerst.dval", 32'(bus.oDVAL), 1);
    #3;
    rstN = 1'b0;
    #1;
    chkAllZero("asyncrst");
    #2;
    rstN = 1'b1;

    // Fresh frame must reproduce the first window exactly.
    first = {12'd32, 12'd33, 12'd34, 12'd16, 12'd17, 12'd18, 12'd0, 12'd1, 12'd2};
    manPulses = 0;
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) begin
        tick(1'b1, 1'b1, 12'(16 * y + x));
        if (bus.oDVAL) manPulses++;
        if (x == 2 && y == 2) begin
          chk("fresh.dval", 32'(bus.oDVAL), 1);
          chk("fresh.done", 32'(bus.oFRAME_DONE), 0);
          chkWin("fresh", first);
          chk("fresh.oX", 32'(bus.oX), 1);
          chk("fresh.oY", 32'(bus.oY), 1);
          chk("fresh.xlsb", 32'(bus.oX_LSB), 1);
          chk("fresh.ylsb", 32'(bus.oY_LSB), 1);
        end
        if (x == 3 && y == 3) begin
          chk("fresh.last_done", 32'(bus.oFRAME_DONE), 1);
          chk("fresh.last_oX", 32'(bus.oX), 2);
          chk("fresh.last_oY", 32'(bus.oY), 2);
          chk("fresh.last_P4", 32'(bus.oP_4), 34);
        end
      end
    end
    chk("fresh.pulses", 32'(manPulses), 4);
    tick(1'b1, 1'b0, '0);
    chk("fresh.hold_dval", 32'(bus.oDVAL), 0);
    chk("fresh.hold_P4", 32'(bus.oP_4), 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/bayer_window_ctrl.md
# bayer_window_ctrl

Raster-scan sequencer that turns the 12-bit Bayer pixel stream from the sensor capture path into the 3×3 neighbourhood windows consumed by the raw-to-grayscale converter. It keeps two line buffers and a 3×3 window register, tracks the pixel position, and drives the nine window pixels and the column/row parity bits. It also marks which windows are valid interior windows and flags the end of each frame. It sits between the capture/CCD data block and the grayscale converter, ahead of the frame store.

## Interface
- WIDTH, 640: pixels per line (≥ 3)
- HEIGHT, 480: lines per frame (≥ 3)
- CW, 11: coordinate counter width; 2^CW > max(WIDTH, HEIGHT)
- iCLK  in  1  pixel clock; all state on rising edge
- iRST_N  in  1  reset, asynchronous, active-low
- iFVAL  in  1  frame valid; low = inter-frame, counters held at 0
- iDVAL  in  1  pixel valid; pixel accepted on edge when iFVAL & iDVAL
- iDATA  in  12  raw Bayer pixel, raster order
- oP_0 … oP_8  out  12 each  window pixels, layout top row 2|1|0, middle 5|4|3, bottom 8|7|6 (P_4 centre)
- oX_LSB, oY_LSB  out  1 each  parity of centre column / row
- oX, oY  out  CW each  centre pixel coordinates
- oDVAL  out  1  window valid strobe
- oFRAME_DONE  out  1  one-cycle pulse with final window of frame

## Operation
- Counters x (0..WIDTH-1) and y (0..HEIGHT). An accepted pixel is at (x, y). After it, x increments; at WIDTH-1, x wraps to 0 and y increments.
- Frame end: y = HEIGHT means the frame is complete. Further accepted pixels are ignored: no buffer writes, no window shift, no oDVAL. This lasts until iFVAL goes low.
- iFVAL low on any edge: x ← 0, y ← 0, no accepts. This re-arms for the next frame. No edge detect is needed.
- Line buffers LB1 and LB2 are WIDTH×12 each, with contents not reset. On accept at column x:
  - read LB1[x] = pixel (x, y-1) and LB2[x] = pixel (x, y-2);
  - write LB2[x] ← old LB1[x] and LB1[x] ← iDATA (read-before-write in the same cycle).
- Window: three rows of three 12-bit registers. On accept every row shifts one column left-to-right:
  - col0 ← new; col1 ← col0; col2 ← col1;
  - rows: top ← LB2[x], middle ← LB1[x], bottom ← iDATA.
  - After the shift, P_0/P_3/P_6 = column x; P_1/P_4/P_7 = x-1; P_2/P_5/P_8 = x-2. The top row is y-2 and the bottom row is y.
- Valid window: the accept is at (x, y) with x ≥ 2, y ≥ 2, y < HEIGHT. The centre is (x-1, y-1).
  - oX ← x-1, oY ← y-1, oX_LSB ← ~x[0], oY_LSB ← ~y[0].
  - Output image is (WIDTH-2)×(HEIGHT-2). Border pixels produce no window.
- Stale columns at x = 0, 1 (left over from the previous line) are never presented with oDVAL high.
- oFRAME_DONE ← 1 together with the oDVAL for the accept at (WIDTH-1, HEIGHT-1).
- No backpressure: downstream must take every oDVAL cycle.

## Timing
- Reset (iRST_N low, asynchronous): x, y, all window registers, oP_*, oX, oY, oX_LSB, oY_LSB, oDVAL and oFRAME_DONE are 0. Line buffers are not cleared.
- Latency: the edge that accepts the pixel updates all outputs. oDVAL is high for exactly the following cycle.
- Non-accept cycles: oDVAL = 0 and oFRAME_DONE = 0; window and coordinate outputs hold their last values.
- Gaps in iDVAL within a line or between lines are legal and change nothing except timing.
- Reset mid-frame: everything above returns to 0 immediately. The first accept after release is treated as (0,0) of a frame only if iFVAL is high. Sources are expected to restart at a frame boundary.
- iFVAL falls mid-frame: the partial frame is abandoned with no oFRAME_DONE. The next frame starts at (0,0) and generates no output until its own x ≥ 2, y ≥ 2.
- Back-to-back accepts at full rate: one window per clock, no bubbles.

## Test plan
- Use WIDTH=4, HEIGHT=4 and iDATA = 16·y + x in continuous stream. First oDVAL follows the accept of (2,2) and must show:
  - P_6=34, P_7=33, P_8=32, P_3=18, P_4=17, P_5=16, P_0=2, P_1=1, P_2=0;
  - oX=1, oY=1, oX_LSB=1, oY_LSB=1.
  - Exactly 4 oDVAL pulses per frame. oFRAME_DONE appears only on the 4th, with centre (2,2), P_4=34.
- Same frame with a random iDVAL duty of 30%: window values, coordinates and pulse count are identical to the continuous case. oDVAL is never high on a non-accept cycle.
- After the frame completes, feed 5 extra pixels with iFVAL high: no oDVAL. Drop iFVAL, then feed a second frame with iDATA = 100 + 16·y + x: first window has P_4=117, P_2=100.
- Drop iFVAL after line 2 of frame 1, then run a full frame 2: no oFRAME_DONE for frame 1. Frame 2 produces exactly 4 windows, all containing only frame-2 data.
- Assert iRST_N low mid-line (asynchronously, between edges): all outputs read 0 before the next edge. After release, a fresh frame reproduces the first test exactly.
- Use WIDTH=640, HEIGHT=480 with a full frame: 638·478 = 304964 oDVAL pulses and one oFRAME_DONE with oX=638, oY=478. oX_LSB/oY_LSB match the centre parity on every window.
